scan_avg_ctrl: RTL and testbench
================================

Name: scan_avg_ctrl

Overview:
- Channel scan sequencer for the speckle sensor readout.
- Steps the analog mux across a configured channel range. For each channel it waits a programmable settle time, launches one averaging run on the avg datapath, and presents the result with a valid/ready handshake.
- Sits between the host/register interface and the avg + ADC chain.

Parameters:
- NB_DATA, 12, width of the averaged sample and of o_data.
- NB_CH, 4, width of the channel index (up to 16 channels).
- NB_SETTLE, 8, width of the settle-time counter.
- TIMEOUT_CYC, 4096, cycles allowed for i_avg_done (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- i_start  in  1  one-cycle pulse: begin a scan; ignored unless idle
- i_stop  in  1  one-cycle pulse: abort after the current channel completes
- i_ch_first  in  NB_CH  first channel of the scan
- i_ch_last  in  NB_CH  last channel of the scan
- i_nSamples  in  3  log2 of samples per channel; forwarded to avg
- i_settle  in  NB_SETTLE  settle cycles after a mux change
- o_mux_sel  out  NB_CH  analog mux select
- o_avg_start  out  1  one-cycle start pulse to avg
- o_avg_nSamples  out  3  latched i_nSamples
- i_avg_done  in  1  avg completion pulse
- i_avg_result  in  NB_DATA  avg result
- o_data  out  NB_DATA  channel result
- o_ch  out  NB_CH  channel index of o_data
- o_valid  out  1  result valid
- i_ready  in  1  consumer ready
- o_err  out  1  result flagged as timed out
- o_busy  out  1  scan in progress
- o_scan_done  out  1  one-cycle pulse at end of scan or abort

Behaviour:
- Reset: state IDLE. o_mux_sel, o_data, o_ch, o_avg_nSamples = 0. o_valid, o_err, o_busy, o_avg_start, o_scan_done = 0. Stop flag cleared.
- Latching: on i_start in IDLE, latch i_ch_first/i_ch_last/i_nSamples/i_settle. Later changes to these inputs do not affect the running scan.
- If i_ch_last < i_ch_first, only i_ch_first is scanned (single channel).
- States:
  - IDLE: on i_start go to SELECT.
  - SELECT: o_mux_sel <= current channel; settle counter <= latched settle; go to SETTLE.
  - SETTLE: decrement counter; leave when it reaches 0. With settle = 0 the block spends exactly 1 cycle in SETTLE.
  - START: o_avg_start = 1 for exactly this cycle; go to WAIT_AVG.
  - WAIT_AVG: on i_avg_done, capture o_data <= i_avg_result and o_ch <= channel; go to OUTPUT. i_avg_done outside WAIT_AVG is ignored.
  - OUTPUT: o_valid = 1, with o_data/o_ch stable. Leave on the cycle with i_ready = 1 (transfer). If the stop flag is set, or the channel equals latched last, go to DONE; otherwise go to NEXT.
  - NEXT: channel + 1; go to SELECT.
  - DONE: o_scan_done = 1 for one cycle; go to IDLE.
- o_busy = 1 in every state except IDLE.
- Stop: i_stop in any non-IDLE state sets a sticky stop flag, cleared in IDLE. The current channel finishes, including its handshake; no further channels are started.
- i_start while busy: ignored. A simultaneous i_start and i_stop in IDLE starts a single-channel scan.
- Backpressure: o_valid may stay high indefinitely; no result is dropped or overwritten.
- Latency: from i_start to o_avg_start is 3 + settle cycles. From i_avg_done to o_valid is 1 cycle.
- Channel counter: NB_CH bits. A scan ending at channel 2^NB_CH - 1 terminates without wrapping.
- rst mid-scan returns the block to IDLE on the next edge and drops any pending o_valid.

Optional Feature:
- Macro: SCAN_AVG_TIMEOUT_EN.
- With the macro: a watchdog counts cycles in WAIT_AVG. On reaching TIMEOUT_CYC without i_avg_done, the block moves to OUTPUT with o_data = 0 and o_err = 1. o_err is held with o_valid and cleared on transfer.
- Without the macro: WAIT_AVG waits forever, o_err is tied 0, and no counter is synthesized.

Decomposition:
- Shared package scan_pkg holds:
  - state encoding localparams (IDLE..DONE);
  - default widths NB_DATA and NB_CH.
- One natural sub-module: scan_out_reg, the output holding register with valid/ready and the o_err flag. The controller FSM stays in scan_avg_ctrl.

Test Plan:
- Basic scan: first = 2, last = 5, settle = 3, i_ready held 1, avg model returns 100 + ch after 10 cycles. Expect 4 results (ch 2..5, data 102..105) in order, one o_scan_done, and o_busy falling one cycle after it.
- Backpressure: same scan with i_ready low for 20 cycles on ch 3. Expect o_valid held with data 103 stable, no o_avg_start issued, and the scan resuming after ready.
- Stop: i_stop pulsed during SETTLE of ch 3 in a 0..7 scan. Expect ch 3 result delivered, no ch 4, o_scan_done, return to IDLE.
- Edges:
  - settle = 0: exactly 1 settle cycle;
  - first = last = 15: single result;
  - last < first (first = 6, last = 1): single ch 6 result.
- Ignored inputs: i_start mid-scan is ignored; a spurious i_avg_done during SETTLE is ignored. Results are unchanged vs. a reference run.
- Timeout: with SCAN_AVG_TIMEOUT_EN, TIMEOUT_CYC = 64, avg never answers. Expect o_valid with o_data = 0 and o_err = 1 at 64 cycles after o_avg_start. rst asserted mid-WAIT_AVG returns all outputs to 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and default widths for the channel scan sequencer.
package scan_pkg;

   localparam int unsigned DEF_NB_DATA   = 12;
   localparam int unsigned DEF_NB_CH     = 4;
   localparam int unsigned DEF_NB_SETTLE = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_START    = 3'd3,
      ST_WAIT_AVG = 3'd4,
      ST_OUTPUT   = 3'd5,
      ST_NEXT     = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

endpackage

// File: rtl/scan_out_reg.sv
// Result holding register: keeps data/channel/error stable while valid waits for ready.
module scan_out_reg
   import scan_pkg::*;
#(
   parameter int unsigned NB_DATA = DEF_NB_DATA,
   parameter int unsigned NB_CH   = DEF_NB_CH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [NB_DATA-1:0] load_data,
   input  logic [NB_CH-1:0]   load_ch,
   input  logic               load_err,
   input  logic               ready,
   output logic [NB_DATA-1:0] data,
   output logic [NB_CH-1:0]   ch,
   output logic               valid,
   output logic               err
);

   // Capture a new result on load; drop valid and the error flag on transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         ch    <= '0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         ch    <= load_ch;
         valid <= 1'b1;
         err   <= load_err;
      end else if (valid && ready) begin
         valid <= 1'b0;
         err   <= 1'b0;
      end
   end

endmodule

// File: rtl/scan_avg_ctrl.sv
// Channel scan sequencer: mux select, settle wait, averaging launch, result handshake.
// Optional averaging watchdog enabled by defining SCAN_AVG_TIMEOUT_EN.
module scan_avg_ctrl
   import scan_pkg::*;
#(
   parameter int unsigned NB_DATA     = DEF_NB_DATA,
   parameter int unsigned NB_CH       = DEF_NB_CH,
   parameter int unsigned NB_SETTLE   = DEF_NB_SETTLE,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic [NB_CH-1:0]     i_ch_first,
   input  logic [NB_CH-1:0]     i_ch_last,
   input  logic [2:0]           i_nSamples,
   input  logic [NB_SETTLE-1:0] i_settle,
   output logic [NB_CH-1:0]     o_mux_sel,
   output logic                 o_avg_start,
   output logic [2:0]           o_avg_nSamples,
   input  logic                 i_avg_done,
   input  logic [NB_DATA-1:0]   i_avg_result,
   output logic [NB_DATA-1:0]   o_data,
   output logic [NB_CH-1:0]     o_ch,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_err,
   output logic                 o_busy,
   output logic                 o_scan_done
);

   state_t                 state, state_next;
   logic [NB_CH-1:0]       ch;
   logic [NB_CH-1:0]       last_q;
   logic [NB_SETTLE-1:0]   settle_q;
   logic [NB_SETTLE-1:0]   settle_cnt;
   logic                   stop_q;
   logic                   stop_any_c;
   logic                   load_c;
   logic [NB_DATA-1:0]     load_data_c;
   logic                   load_err_c;

   assign stop_any_c = stop_q | i_stop;

`ifdef SCAN_AVG_TIMEOUT_EN
   localparam int unsigned NB_WD = $clog2(TIMEOUT_CYC + 1);
   logic [NB_WD-1:0] wd_cnt;
   logic             timeout_c;

   // Watchdog: counts from 1 in the first WAIT_AVG cycle, so a timeout lands TIMEOUT_CYC cycles after the start pulse.
   always_ff @(posedge clk) begin
      if (rst)
         wd_cnt <= '0;
      else if (state == ST_START)
         wd_cnt <= NB_WD'(1);
      else if (state == ST_WAIT_AVG)
         wd_cnt <= wd_cnt + NB_WD'(1);
   end

   assign timeout_c = (wd_cnt == NB_WD'(TIMEOUT_CYC - 1));
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state logic and result capture request.
   always_comb begin
      state_next  = state;
      load_c      = 1'b0;
      load_data_c = '0;
      load_err_c  = 1'b0;
      case (state)
         ST_IDLE:     if (i_start) state_next = ST_SELECT;
         ST_SELECT:   state_next = ST_SETTLE;
         ST_SETTLE:   if (settle_cnt == '0) state_next = ST_START;
         ST_START:    state_next = ST_WAIT_AVG;
         ST_WAIT_AVG: begin
            if (i_avg_done) begin
               load_c      = 1'b1;
               load_data_c = i_avg_result;
               state_next  = ST_OUTPUT;
            end
`ifdef SCAN_AVG_TIMEOUT_EN
            else if (timeout_c) begin
               load_c     = 1'b1;
               load_err_c = 1'b1;
               state_next = ST_OUTPUT;
            end
`endif
         end
         ST_OUTPUT:   if (i_ready) state_next = (stop_any_c || ch == last_q) ? ST_DONE : ST_NEXT;
         ST_NEXT:     state_next = stop_any_c ? ST_DONE : ST_SELECT;
         ST_DONE:     state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // Scan configuration latches, channel/settle counters and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch             <= '0;
         last_q         <= '0;
         settle_q       <= '0;
         settle_cnt     <= '0;
         stop_q         <= 1'b0;
         o_mux_sel      <= '0;
         o_avg_nSamples <= '0;
         o_avg_start    <= 1'b0;
         o_busy         <= 1'b0;
         o_scan_done    <= 1'b0;
      end else begin
         o_avg_start <= (state_next == ST_START);
         o_busy      <= (state_next != ST_IDLE);
         o_scan_done <= (state_next == ST_DONE);
         // A stop arriving together with start limits the scan to its first channel.
         stop_q      <= (state == ST_IDLE) ? (i_start & i_stop) : (stop_q | i_stop);
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  ch             <= i_ch_first;
                  last_q         <= (i_ch_last < i_ch_first) ? i_ch_first : i_ch_last;
                  settle_q       <= i_settle;
                  o_avg_nSamples <= i_nSamples;
               end
            end
            ST_SELECT: begin
               o_mux_sel  <= ch;
               settle_cnt <= settle_q;
            end
            ST_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - NB_SETTLE'(1);
            ST_NEXT:   ch <= ch + NB_CH'(1);
            default: ;
         endcase
      end
   end

   scan_out_reg #(
      .NB_DATA (NB_DATA),
      .NB_CH   (NB_CH)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .load      (load_c),
      .load_data (load_data_c),
      .load_ch   (ch),
      .load_err  (load_err_c),
      .ready     (i_ready),
      .data      (o_data),
      .ch        (o_ch),
      .valid     (o_valid),
      .err       (o_err)
   );

endmodule

// File: tb/tb_scan_avg_ctrl.sv
// Self-checking bench for scan_avg_ctrl: directed and randomized scans against a behavioural avg/scan model.
module tb_scan_avg_ctrl;

   localparam int unsigned NB_DATA   = 12;
   localparam int unsigned NB_CH     = 4;
   localparam int unsigned NB_SETTLE = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 i_start, i_stop, i_ready;
   logic [NB_CH-1:0]     i_ch_first, i_ch_last;
   logic [2:0]           i_nSamples;
   logic [NB_SETTLE-1:0] i_settle;
   logic [NB_CH-1:0]     o_mux_sel, o_ch;
   logic                 o_avg_start, o_valid, o_err, o_busy, o_scan_done;
   logic [2:0]           o_avg_nSamples;
   logic                 i_avg_done;
   logic [NB_DATA-1:0]   i_avg_result, o_data;
   logic                 model_done, spur_done;

   assign i_avg_done = model_done | spur_done;

   always #5 clk = ~clk;

   scan_avg_ctrl #(.TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
      .i_ch_first(i_ch_first), .i_ch_last(i_ch_last), .i_nSamples(i_nSamples),
      .i_settle(i_settle), .o_mux_sel(o_mux_sel), .o_avg_start(o_avg_start),
      .o_avg_nSamples(o_avg_nSamples), .i_avg_done(i_avg_done),
      .i_avg_result(i_avg_result), .o_data(o_data), .o_ch(o_ch), .o_valid(o_valid),
      .i_ready(i_ready), .o_err(o_err), .o_busy(o_busy), .o_scan_done(o_scan_done)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Shared model state (scenario writes config, monitor writes observations).
   logic [NB_DATA-1:0] tab [16];
   int                 avg_lat = 10;
   bit                 avg_mute = 1'b0;
   logic [15:0]        got_q [$];
   int                 n_avg_start = 0;
   int                 n_scan_done = 0;

   // Monitor-private state
   int               cyc = 0;
   bit               avg_pend = 1'b0, done_prev = 1'b0, lat_armed = 1'b0, xfer_armed = 1'b0, prev_hold = 1'b0;
   int               avg_cnt, start_cyc, xfer_cyc, exp_settle;
   logic [NB_CH-1:0] avg_ch, exp_ch, hold_ch;
   logic [2:0]       exp_ns;
   logic [NB_DATA-1:0] hold_data;

   // Behavioural avg responder plus protocol/latency monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         avg_pend = 0; done_prev = 0; lat_armed = 0; xfer_armed = 0; prev_hold = 0;
         model_done = 1'b0;
      end else begin
         if (done_prev) begin
            check_eq("done_to_valid", 32'(o_valid), 32'd1);
            check_eq("cap_ch", 32'(o_ch), 32'(avg_ch));
            check_eq("cap_data", 32'(o_data), 32'(tab[avg_ch]));
         end
         if (prev_hold) begin
            check_eq("hold_valid", 32'(o_valid), 32'd1);
            check_eq("hold_data", 32'(o_data), 32'(hold_data));
            check_eq("hold_ch", 32'(o_ch), 32'(hold_ch));
         end
         if (o_valid) check_eq("no_start_while_valid", 32'(o_avg_start), 32'd0);
         if (i_start && !o_busy) begin
            start_cyc = cyc; lat_armed = 1; xfer_armed = 0;
            exp_settle = int'(i_settle); exp_ns = i_nSamples; exp_ch = i_ch_first;
         end
         model_done = 1'b0;
         if (avg_pend) begin
            if (avg_cnt <= 1) begin
               model_done = 1'b1; i_avg_result = tab[avg_ch]; avg_pend = 0;
            end else avg_cnt--;
         end
         done_prev = model_done;
         if (o_avg_start) begin
            n_avg_start++;
            if (lat_armed) check_eq("start_lat", cyc - start_cyc, 3 + exp_settle);
            if (xfer_armed) check_eq("next_lat", cyc - xfer_cyc, 4 + exp_settle);
            lat_armed = 0; xfer_armed = 0;
            check_eq("mux_sel", 32'(o_mux_sel), 32'(exp_ch));
            check_eq("nsamples", 32'(o_avg_nSamples), 32'(exp_ns));
            exp_ch = exp_ch + 4'd1;
            if (!avg_mute) begin avg_pend = 1; avg_cnt = avg_lat; avg_ch = o_mux_sel; end
         end
         prev_hold = o_valid && !i_ready;
         hold_data = o_data; hold_ch = o_ch;
         if (o_valid && i_ready) begin
            got_q.push_back({o_ch, o_data});
            if (!avg_mute) check_eq("err_flag", 32'(o_err), 32'd0);
            xfer_cyc = cyc; xfer_armed = 1;
         end
         if (o_scan_done) n_scan_done++;
      end
   end

   // One complete scan: drive, apply ready/stop/noise, then compare collected results with the reference list.
   task automatic run_scan(input int first, input int last, input int settle, input int stop_ch,
                           input int ready_pct, input int bp_ch, input int bp_len,
                           input bit noise, input bit ss, input bit rnd_tab);
      logic [15:0] exp_q [$];
      int  eff_last, end_ch, base_st, base_got, base_sd, bp_left;
      bit  stop_sent, seen_done, bp_done;
      eff_last = (last < first) ? first : last;
      end_ch   = ss ? first : ((stop_ch >= 0) ? stop_ch : eff_last);
      for (int c = 0; c < 16; c++) tab[c] = rnd_tab ? NB_DATA'($urandom) : NB_DATA'(100 + c);
      for (int c = first; c <= end_ch; c++) exp_q.push_back({4'(c), tab[c]});
      base_st = n_avg_start; base_got = got_q.size(); base_sd = n_scan_done;
      i_ch_first = 4'(first); i_ch_last = 4'(last); i_settle = 8'(settle);
      i_nSamples = 3'($urandom_range(7));
      i_start = 1'b1; i_stop = ss; i_ready = 1'b1;
      tick();
      i_start = 1'b0; i_stop = 1'b0;
      stop_sent = ss; seen_done = 0; bp_left = bp_len; bp_done = 0;
      for (int t = 0; t < 3000 && !seen_done; t++) begin
         if (bp_ch >= 0 && !bp_done && o_valid && int'(o_ch) == bp_ch) begin
            if (bp_left > 0) begin i_ready = 1'b0; bp_left--; end
            else begin
               check_eq("bp_data", 32'(o_data), 32'(tab[bp_ch]));
               i_ready = 1'b1; bp_done = 1;
            end
         end else i_ready = ($urandom_range(99) < ready_pct);
         i_stop = (stop_ch >= 0 && !stop_sent && n_avg_start - base_st == stop_ch - first
                   && int'(o_mux_sel) == stop_ch);
         if (i_stop) stop_sent = 1;
         spur_done = noise && t == 1;
         i_start   = noise && t == 1;
         if (noise && t == 1) begin
            i_ch_first = 4'($urandom); i_ch_last = 4'($urandom);
            i_settle = 8'($urandom); i_nSamples = 3'($urandom);
         end
         if (o_scan_done) begin
            seen_done = 1;
            check_eq("busy_in_done", 32'(o_busy), 32'd1);
         end
         tick();
      end
      i_stop = 1'b0; spur_done = 1'b0; i_start = 1'b0;
      check_eq("scan_finished", 32'(seen_done), 32'd1);
      check_eq("busy_fall", 32'(o_busy), 32'd0);
      check_eq("scan_done_count", n_scan_done - base_sd, 1);
      check_eq("n_results", got_q.size() - base_got, exp_q.size());
      for (int i = 0; i < exp_q.size() && base_got + i < got_q.size(); i++)
         check_eq("result", 32'(got_q[base_got + i]), 32'(exp_q[i]));
      tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_mux"},   32'(o_mux_sel), 32'd0);
      check_eq({tag, "_data"},  32'(o_data), 32'd0);
      check_eq({tag, "_ch"},    32'(o_ch), 32'd0);
      check_eq({tag, "_ns"},    32'(o_avg_nSamples), 32'd0);
      check_eq({tag, "_flags"}, 32'({o_valid, o_err, o_busy, o_avg_start, o_scan_done}), 32'd0);
   endtask

   initial begin
      int f, l, sc, bp, wait_t;
      bit ok;
      rst = 1'b1; i_start = 0; i_stop = 0; i_ready = 0; spur_done = 0; model_done = 0;
      i_ch_first = '0; i_ch_last = '0; i_nSamples = '0; i_settle = '0; i_avg_result = '0;
      repeat (3) tick();
      check_outputs_zero("reset");
      rst = 1'b0;
      tick();

      // Directed scans
      avg_lat = 10;
      run_scan(2, 5, 3, -1, 100, -1, 0, 0, 0, 0);   // basic
      run_scan(2, 5, 3, -1, 100, 3, 20, 0, 0, 0);   // backpressure on ch 3
      run_scan(0, 7, 2, 3, 100, -1, 0, 0, 0, 0);    // stop during ch 3
      run_scan(4, 6, 0, -1, 100, -1, 0, 0, 0, 0);   // settle = 0
      run_scan(15, 15, 1, -1, 100, -1, 0, 0, 0, 0); // top channel, no wrap
      run_scan(6, 1, 2, -1, 100, -1, 0, 0, 0, 0);   // last < first
      run_scan(9, 12, 1, -1, 100, -1, 0, 0, 1, 0);  // start+stop together
      run_scan(1, 4, 2, -1, 100, -1, 0, 1, 0, 0);   // ignored start/done/config changes
      run_scan(13, 15, 0, -1, 60, -1, 0, 0, 0, 1);

      // Randomized scans
      for (int n = 0; n < 30; n++) begin
         f = int'($urandom_range(15)); l = int'($urandom_range(15));
         sc = int'($urandom_range(6)); avg_lat = int'($urandom_range(1, 15));
         bp = -1;
         if ($urandom_range(3) == 0) bp = (l < f) ? f : int'($urandom_range(l, f));
         run_scan(f, l, sc, bp, int'($urandom_range(40, 100)), -1, 0,
                  $urandom_range(3) == 0, $urandom_range(9) == 0, 1);
      end

      // Reset while a result is pending
      avg_lat = 4;
      i_ch_first = 4'd3; i_ch_last = 4'd9; i_settle = 8'd1; i_ready = 1'b0;
      i_start = 1'b1; tick(); i_start = 1'b0;
      ok = 0;
      for (int t = 0; t < 200 && !ok; t++) begin ok = o_valid; if (!ok) tick(); end
      check_eq("pre_rst_valid", 32'(ok), 32'd1);
      rst = 1'b1; tick();
      check_outputs_zero("mid_rst");
      rst = 1'b0; i_ready = 1'b1; tick();
      avg_lat = 7;
      run_scan(0, 2, 1, -1, 100, -1, 0, 0, 0, 1);

`ifdef SCAN_AVG_TIMEOUT_EN
      // Averaging never answers: timeout result after 64 cycles, then reset mid-wait.
      avg_mute = 1'b1;
      i_ch_first = 4'd5; i_ch_last = 4'd5; i_settle = 8'd0; i_ready = 1'b0;
      i_start = 1'b1; tick(); i_start = 1'b0;
      ok = 0;
      for (int t = 0; t < 50 && !ok; t++) begin ok = o_avg_start; if (!ok) tick(); end
      check_eq("to_avg_start", 32'(ok), 32'd1);
      wait_t = 0;
      while (!o_valid && wait_t < 200) begin tick(); wait_t++; end
      check_eq("to_latency", wait_t, 64);
      check_eq("to_data", 32'(o_data), 32'd0);
      check_eq("to_err", 32'(o_err), 32'd1);
      i_ready = 1'b1; tick();
      check_eq("to_err_clr", 32'(o_err), 32'd0);
      repeat (3) tick();
      i_start = 1'b1; tick(); i_start = 1'b0;
      repeat (10) tick();
      rst = 1'b1; tick();
      check_outputs_zero("to_rst");
      rst = 1'b0; avg_mute = 1'b0; tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
